frame_pattern_checker: RTL and testbench
========================================

Name: frame_pattern_checker

Overview:
Parametrised successor to the single-stream front-end data checker. It consumes tagged 16-bit frame words and decodes the 6-word header. It verifies the data-word test pattern and the frame length, then checks for the trailer. It reports per-event status plus running header, good-event and bad-event counters to the slow-control readout. It sits between the ADC/link frame output and the register bank, one instance per link.

Parameters:
NDATA, 1024, data words per event (2..65535)
STEP, 16, data words per pattern step; payload increments at each multiple of STEP (power of two, 1..NDATA)
CW, 32, width of the event/header counters

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active-high
idata  in  16  frame word; [15:14] tag, [13:0] payload
ivalid  in  1  idata valid this cycle; words with ivalid=0 are ignored
cnt_header  out  CW  complete headers seen
cnt_evt  out  CW  events closed with no error
cnt_bad  out  CW  events closed with error
evt_done  out  1  one-cycle pulse when an event closes
b_err  out  1  status of the last closed event (1 = bad)
err_cause  out  5  cause bits of the last closed event
cnt_mismatch  out  16  pattern mismatches in the last closed event (saturating)
timestamp_reg  out  29  decoded header field
ispill_reg  out  10  decoded header field
ievt_reg  out  16  decoded header field
cbit_reg  out  16  decoded header field
icrate_reg  out  5  decoded header field
islot_reg  out  5  decoded header field

Behaviour:
- Tags: 11 = header, 10 = data, 01 = trailer, 00 = idle. Only words with ivalid=1 are examined.
- Reset: all outputs are 0, the FSM is in IDLE, and all internal counters are 0. Reset asserted mid-event discards the event; nothing is counted.
- Header unpack (hN = payload of header word N):
  - icrate = h0[4:0]; islot = h0[9:5]; ispill = {h1[5:0],h0[13:10]}
  - ievt = {h2[7:0],h1[13:6]}; timestamp = {h4[8:0],h3,h2[13:8]}; cbit = {h5[10:0],h4[13:9]}
  - Field registers and cnt_header update on the clock edge that accepts h5.
- FSM states IDLE, HDR, DATA, TRL:
  - IDLE: tag 11 → store h0, hcnt=1, go HDR. Other tags are dropped silently.
  - HDR: tag 11 with hcnt<6 → store the word. Tag 10 with hcnt==6 → this word is d[0], go DATA. Any other word → err bit0 (header) set, event closed bad. If that word is tag 11, it restarts as h0 (HDR); otherwise go IDLE.
  - DATA: for k>0, expect d[k]==d[k-1] when k%STEP!=0, else d[k]==d[k-1]+1 mod 2^14. A miss sets err bit1 (pattern) and increments cnt_mismatch. After d[NDATA-1], go TRL.
  - DATA, short frame: a non-10 word before NDATA words sets err bit2 (length) and closes the event bad. A tag 11 word restarts as h0, a tag 01 word is consumed, and tag 00 returns to IDLE.
  - TRL: tag 01 → close the event and go IDLE. Tag 10 → err bit2 (overlong); stay in TRL, consuming data words until a non-10 word. Tag 11 or 00 → err bit3 (trailer) and close; tag 11 restarts as h0.
- Close: evt_done pulses for exactly one cycle, on the edge after the closing word. On the same edge:
  - b_err = |err_cause.
  - Exactly one of cnt_evt / cnt_bad increments.
  - err_cause and cnt_mismatch latch the event values; the internal accumulators clear.
- Counters wrap modulo 2^CW; cnt_mismatch saturates at 16'hFFFF.
- Close and restart in the same cycle are allowed: the closing word is also accepted as h0.

Optional Feature:
EVT_SEQ_CHECK_EN:
- Defined: each header-complete event compares ievt against the previous closed event's ievt+1 (mod 2^16). A mismatch sets err_cause bit4 (sequence). The first event after reset is exempt.
- Undefined: bit4 is tied to 0 and no previous-ievt register exists.

Decomposition:
- Package chk_pkg holds:
  - tag constants TAG_HDR/TAG_DATA/TAG_TRL/TAG_IDLE
  - state enum
  - err_cause bit indices ERR_HDR, ERR_PAT, ERR_LEN, ERR_TRL, ERR_SEQ
  - NHDR=6
- Sub-module hdr_decode is the natural split: it maps the six 14-bit header payloads to the field values, and the top registers them.

Test Plan:
- Good event, STEP=16, NDATA=1024: 6 headers (crate 3, slot 7, evt 0x1234), data starting 0x0000 incrementing every 16 words, trailer → evt_done one pulse, cnt_evt=1, b_err=0, icrate_reg=3, islot_reg=7, ievt_reg=0x1234.
- Same event with d[100] corrupted by +5 → b_err=1, err_cause=5'b00010, cnt_mismatch=2, cnt_bad=1.
- Trailer after 1000 data words → err_cause bit2, cnt_bad=1. A header 3 idle cycles later, followed by a good event → cnt_evt=1.
- Good event with ivalid toggled randomly at 50 % → identical result to the gap-free case.
- Header word arrives in TRL → err bit3, event closed bad, and the next event decodes correctly from that word as h0.
- EVT_SEQ_CHECK_EN: events with ievt 5, 6, 8 → the third sets bit4. Reset asserted at data word 500 → all counters read 0 and no evt_done pulse.

Source files
------------

// File: rtl/chk_pkg.sv
// Shared definitions for the frame pattern checker: word tags, FSM states,
// error-cause bit positions and the header length.
package chk_pkg;

    localparam logic [1:0] TAG_HDR  = 2'b11;
    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_TRL  = 2'b01;
    localparam logic [1:0] TAG_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRL
    } state_t;

    localparam int ERR_HDR = 0;
    localparam int ERR_PAT = 1;
    localparam int ERR_LEN = 2;
    localparam int ERR_TRL = 3;
    localparam int ERR_SEQ = 4;
    localparam int NERR    = 5;

    localparam int NHDR = 6;

endpackage

// File: rtl/hdr_decode.sv
// Header field decoder: maps the six 14-bit header payloads onto the
// readout fields. Purely combinational; the top registers the results.
// Only the low 11 bits of the last header word carry information.
module hdr_decode (
    input  logic [13:0] h0,
    input  logic [13:0] h1,
    input  logic [13:0] h2,
    input  logic [13:0] h3,
    input  logic [13:0] h4,
    input  logic [10:0] h5,
    output logic [4:0]  icrate,
    output logic [4:0]  islot,
    output logic [9:0]  ispill,
    output logic [15:0] ievt,
    output logic [28:0] timestamp,
    output logic [15:0] cbit
);

    assign icrate    = h0[4:0];
    assign islot     = h0[9:5];
    assign ispill    = {h1[5:0], h0[13:10]};
    assign ievt      = {h2[7:0], h1[13:6]};
    assign timestamp = {h4[8:0], h3, h2[13:8]};
    assign cbit      = {h5, h4[13:9]};

endmodule

// File: rtl/frame_pattern_checker.sv
// Frame pattern checker: walks header / data / trailer framing of one link,
// verifies the stepped data pattern and the frame length, and keeps running
// header, good-event and bad-event counters for slow-control readout.
// Optional build macro: EVT_SEQ_CHECK_EN enables the event-number sequence
// check (err_cause bit 4); without it that bit is tied low.
module frame_pattern_checker
    import chk_pkg::*;
#(
    parameter int NDATA = 1024,
    parameter int STEP  = 16,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   idata,
    input  logic          ivalid,
    output logic [CW-1:0] cnt_header,
    output logic [CW-1:0] cnt_evt,
    output logic [CW-1:0] cnt_bad,
    output logic          evt_done,
    output logic          b_err,
    output logic [4:0]    err_cause,
    output logic [15:0]   cnt_mismatch,
    output logic [28:0]   timestamp_reg,
    output logic [9:0]    ispill_reg,
    output logic [15:0]   ievt_reg,
    output logic [15:0]   cbit_reg,
    output logic [4:0]    icrate_reg,
    output logic [4:0]    islot_reg
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    HDR_LAST = 3'(NHDR - 1);
    localparam logic [2:0]    HDR_FULL = 3'(NHDR);
    localparam logic [15:0]   D_LAST   = 16'(NDATA - 1);
    localparam logic [15:0]   STEP_MSK = 16'(STEP - 1);

    // Mismatch count sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]      tag;
    logic [13:0]     payload;
    state_t          state;
    logic [2:0]      hcnt;
    logic [15:0]     dcnt;
    logic [13:0]     prev_d;
    logic [NERR-1:0] err_acc;
    logic [15:0]     mism_acc;
    logic [13:0]     hdr_mem [0:NHDR-2];

    logic [4:0]      dec_icrate;
    logic [4:0]      dec_islot;
    logic [9:0]      dec_ispill;
    logic [15:0]     dec_ievt;
    logic [28:0]     dec_timestamp;
    logic [15:0]     dec_cbit;

    logic            at_step;
    logic [13:0]     exp_d;
    logic            pat_miss;
    logic            seq_err;
    logic            close;
    logic [NERR-1:0] close_bits;
    logic [NERR-1:0] final_err;

    assign tag     = idata[15:14];
    assign payload = idata[13:0];

    // The word currently on idata stands in for h5 when the header completes.
    hdr_decode u_hdr_decode (
        .h0        (hdr_mem[0]),
        .h1        (hdr_mem[1]),
        .h2        (hdr_mem[2]),
        .h3        (hdr_mem[3]),
        .h4        (hdr_mem[4]),
        .h5        (payload[10:0]),
        .icrate    (dec_icrate),
        .islot     (dec_islot),
        .ispill    (dec_ispill),
        .ievt      (dec_ievt),
        .timestamp (dec_timestamp),
        .cbit      (dec_cbit)
    );

    // Data word k bumps by one at every multiple of STEP, otherwise repeats.
    assign at_step  = (dcnt & STEP_MSK) == 16'd0;
    assign exp_d    = at_step ? prev_d + 14'd1 : prev_d;
    assign pat_miss = (payload != exp_d);

`ifdef EVT_SEQ_CHECK_EN
    logic [15:0] prev_ievt;
    logic        have_prev;
    logic        hdr_ok;
    assign seq_err = have_prev && (dec_ievt != prev_ievt + 16'd1);
`else
    assign seq_err = 1'b0;
`endif

    // Decide whether the current valid word closes the open event, and with which extra causes.
    always_comb begin
        close      = 1'b0;
        close_bits = '0;
        if (ivalid) begin
            case (state)
                ST_HDR: begin
                    if (!((tag == TAG_HDR && hcnt < HDR_FULL) ||
                          (tag == TAG_DATA && hcnt == HDR_FULL))) begin
                        close               = 1'b1;
                        close_bits[ERR_HDR] = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tag != TAG_DATA) begin
                        close               = 1'b1;
                        close_bits[ERR_LEN] = 1'b1;
                    end
                end
                ST_TRL: begin
                    if (tag == TAG_TRL) begin
                        close = 1'b1;
                    end else if (tag != TAG_DATA) begin
                        close               = 1'b1;
                        close_bits[ERR_TRL] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        final_err = err_acc | close_bits;
    end

    // Framing FSM with event accumulators, close reporting and readout counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hcnt          <= '0;
            dcnt          <= '0;
            prev_d        <= '0;
            err_acc       <= '0;
            mism_acc      <= '0;
            for (int i = 0; i < NHDR - 1; i++) hdr_mem[i] <= '0;
            cnt_header    <= '0;
            cnt_evt       <= '0;
            cnt_bad       <= '0;
            evt_done      <= 1'b0;
            b_err         <= 1'b0;
            err_cause     <= '0;
            cnt_mismatch  <= '0;
            timestamp_reg <= '0;
            ispill_reg    <= '0;
            ievt_reg      <= '0;
            cbit_reg      <= '0;
            icrate_reg    <= '0;
            islot_reg     <= '0;
`ifdef EVT_SEQ_CHECK_EN
            prev_ievt     <= '0;
            have_prev     <= 1'b0;
            hdr_ok        <= 1'b0;
`endif
        end else begin
            evt_done <= 1'b0;
            if (close) begin
                evt_done     <= 1'b1;
                err_cause    <= final_err;
                b_err        <= |final_err;
                cnt_mismatch <= mism_acc;
                if (|final_err) cnt_bad <= cnt_bad + CNT_ONE;
                else            cnt_evt <= cnt_evt + CNT_ONE;
                err_acc  <= '0;
                mism_acc <= '0;
`ifdef EVT_SEQ_CHECK_EN
                if (hdr_ok) begin
                    prev_ievt <= ievt_reg;
                    have_prev <= 1'b1;
                end
                hdr_ok <= 1'b0;
`endif
                // A closing header word opens the next event as its h0.
                if (tag == TAG_HDR) begin
                    hdr_mem[0] <= payload;
                    hcnt       <= 3'd1;
                    state      <= ST_HDR;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (ivalid) begin
                case (state)
                    ST_IDLE: begin
                        if (tag == TAG_HDR) begin
                            hdr_mem[0] <= payload;
                            hcnt       <= 3'd1;
                            state      <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (tag == TAG_HDR) begin
                            if (hcnt == HDR_LAST) begin
                                icrate_reg       <= dec_icrate;
                                islot_reg        <= dec_islot;
                                ispill_reg       <= dec_ispill;
                                ievt_reg         <= dec_ievt;
                                timestamp_reg    <= dec_timestamp;
                                cbit_reg         <= dec_cbit;
                                cnt_header       <= cnt_header + CNT_ONE;
                                err_acc[ERR_SEQ] <= seq_err;
`ifdef EVT_SEQ_CHECK_EN
                                hdr_ok           <= 1'b1;
`endif
                            end else begin
                                hdr_mem[hcnt] <= payload;
                            end
                            hcnt <= hcnt + 3'd1;
                        end else begin
                            prev_d <= payload;
                            dcnt   <= 16'd1;
                            state  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (pat_miss) begin
                            err_acc[ERR_PAT] <= 1'b1;
                            mism_acc         <= sat_inc(mism_acc);
                        end
                        prev_d <= payload;
                        dcnt   <= dcnt + 16'd1;
                        if (dcnt == D_LAST) state <= ST_TRL;
                    end
                    ST_TRL: begin
                        err_acc[ERR_LEN] <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_pattern_checker.sv
// Self-checking bench for frame_pattern_checker. Expected close results are
// queued when an event is generated and compared when evt_done fires.
module tb_frame_pattern_checker;

    localparam int NDATA = 1024;
    localparam int STEP  = 16;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   idata = '0;
    logic          ivalid = 1'b0;
    logic [CW-1:0] cnt_header, cnt_evt, cnt_bad;
    logic          evt_done, b_err;
    logic [4:0]    err_cause;
    logic [15:0]   cnt_mismatch;
    logic [28:0]   timestamp_reg;
    logic [9:0]    ispill_reg;
    logic [15:0]   ievt_reg, cbit_reg;
    logic [4:0]    icrate_reg, islot_reg;

    frame_pattern_checker #(.NDATA(NDATA), .STEP(STEP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid),
        .cnt_header(cnt_header), .cnt_evt(cnt_evt), .cnt_bad(cnt_bad),
        .evt_done(evt_done), .b_err(b_err), .err_cause(err_cause),
        .cnt_mismatch(cnt_mismatch), .timestamp_reg(timestamp_reg),
        .ispill_reg(ispill_reg), .ievt_reg(ievt_reg), .cbit_reg(cbit_reg),
        .icrate_reg(icrate_reg), .islot_reg(islot_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  err;
        logic [15:0] mism;
        int          evt;
        int          bad;
        int          hdr;
        bit          chkf;
        logic [15:0] ievt;
        logic [4:0]  crate;
        logic [4:0]  slot;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_evt = 0, exp_bad = 0, exp_hdr = 0;
    int   done_count = 0;

    function automatic logic [28:0] ts_of(input logic [15:0] e);
        return 29'(e) * 29'd1001 + 29'd17;
    endfunction
    function automatic logic [9:0] spill_of(input logic [15:0] e);
        return 10'(e * 16'd7);
    endfunction
    function automatic logic [15:0] cbit_of(input logic [15:0] e);
        return ~e;
    endfunction

    // Scoreboard side: every closed event must match the oldest queued expectation.
    always @(negedge clk) begin
        if (evt_done) begin
            done_count++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_evt_done got=1 want=0");
            end else begin
                mon_e = sbq.pop_front();
                if (err_cause !== mon_e.err) begin
                    errors++; $display("FAIL err_cause got=%b want=%b", err_cause, mon_e.err);
                end
                checks++;
                if (b_err !== (|mon_e.err)) begin
                    errors++; $display("FAIL b_err got=%b want=%b", b_err, |mon_e.err);
                end
                checks++;
                if (cnt_mismatch !== mon_e.mism) begin
                    errors++; $display("FAIL cnt_mismatch got=%0d want=%0d", cnt_mismatch, mon_e.mism);
                end
                checks++;
                if (cnt_evt !== CW'(mon_e.evt) || cnt_bad !== CW'(mon_e.bad)) begin
                    errors++;
                    $display("FAIL evt_counters got=%0d/%0d want=%0d/%0d", cnt_evt, cnt_bad, mon_e.evt, mon_e.bad);
                end
                checks++;
                if (cnt_header !== CW'(mon_e.hdr)) begin
                    errors++; $display("FAIL cnt_header got=%0d want=%0d", cnt_header, mon_e.hdr);
                end
                if (mon_e.chkf) begin
                    checks++;
                    if (ievt_reg !== mon_e.ievt || icrate_reg !== mon_e.crate || islot_reg !== mon_e.slot ||
                        timestamp_reg !== ts_of(mon_e.ievt) || ispill_reg !== spill_of(mon_e.ievt) ||
                        cbit_reg !== cbit_of(mon_e.ievt)) begin
                        errors++;
                        $display("FAIL hdr_fields got=%h/%0d/%0d/%h/%h/%h want=%h/%0d/%0d/%h/%h/%h",
                                 ievt_reg, icrate_reg, islot_reg, timestamp_reg, ispill_reg, cbit_reg,
                                 mon_e.ievt, mon_e.crate, mon_e.slot, ts_of(mon_e.ievt),
                                 spill_of(mon_e.ievt), cbit_of(mon_e.ievt));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ivalid = 1'b0;
            idata  = '0;
        end
    endtask

    task automatic put(input logic [1:0] tag, input logic [13:0] pl, input bit gaps);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                @(posedge clk); #1;
                ivalid = 1'b0;
                idata  = 16'($urandom);
            end
        end
        @(posedge clk); #1;
        idata  = {tag, pl};
        ivalid = 1'b1;
    endtask

    task automatic push_exp(input logic [4:0] err, input logic [15:0] mism, input bit chkf,
                            input logic [15:0] e, input logic [4:0] crate, input logic [4:0] slot);
        exp_t x;
        if (|err) exp_bad++;
        else      exp_evt++;
        x.err = err; x.mism = mism; x.evt = exp_evt; x.bad = exp_bad; x.hdr = exp_hdr;
        x.chkf = chkf; x.ievt = e; x.crate = crate; x.slot = slot;
        sbq.push_back(x);
    endtask

    task automatic send_header(input logic [15:0] e, input logic [4:0] crate, input logic [4:0] slot,
                               input bit gaps);
        logic [28:0] ts;
        logic [9:0]  sp;
        logic [15:0] cb;
        ts = ts_of(e); sp = spill_of(e); cb = cbit_of(e);
        put(2'b11, {sp[3:0], slot, crate}, gaps);
        put(2'b11, {e[7:0], sp[9:4]}, gaps);
        put(2'b11, {ts[5:0], e[15:8]}, gaps);
        put(2'b11, ts[19:6], gaps);
        put(2'b11, {cb[4:0], ts[28:20]}, gaps);
        put(2'b11, {3'b000, cb[15:5]}, gaps);
    endtask

    // trl: 0 = tag-01 trailer, 1 = no trailer (next word closes it)
    task automatic send_event(input logic [15:0] e, input logic [4:0] crate, input logic [4:0] slot,
                              input int ndw, input int cidx, input int cadd, input int trl,
                              input bit gaps, input logic [4:0] xerr, input logic [15:0] xmism);
        logic [13:0] d;
        exp_hdr++;
        push_exp(xerr, xmism, 1'b1, e, crate, slot);
        send_header(e, crate, slot, gaps);
        for (int k = 0; k < ndw; k++) begin
            d = 14'(k / STEP);
            if (k == cidx) d = d + 14'(cadd);
            put(2'b10, d, gaps);
        end
        if (trl == 0) put(2'b01, 14'h0, gaps);
    endtask

    task automatic wait_drain();
        idle(2);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) idle(1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ivalid = 1'b0; idata = '0;
        idle(3);
        rst = 1'b0;
        sbq.delete();
        exp_evt = 0; exp_bad = 0; exp_hdr = 0;
        idle(1);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; ivalid = 1'b1; idata = 16'hC000;
        idle(3);
        checks++;
        if (cnt_header !== '0 || cnt_evt !== '0 || cnt_bad !== '0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", cnt_header, cnt_evt, cnt_bad);
        end
        checks++;
        if (evt_done !== 1'b0 || b_err !== 1'b0 || err_cause !== 5'd0 || cnt_mismatch !== 16'd0) begin
            errors++; $display("FAIL reset_status got=%b/%b/%b/%0d want=0/0/0/0", evt_done, b_err, err_cause, cnt_mismatch);
        end
        checks++;
        if (ievt_reg !== '0 || icrate_reg !== '0 || islot_reg !== '0 || timestamp_reg !== '0 ||
            ispill_reg !== '0 || cbit_reg !== '0) begin
            errors++; $display("FAIL reset_fields got=%h/%h/%h want=0", ievt_reg, icrate_reg, islot_reg);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_good();
        int dc;
        do_reset();
        dc = done_count;
        send_event(16'h1234, 5'd3, 5'd7, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        wait_drain();
        checks++;
        if (done_count - dc !== 1 || evt_done !== 1'b0) begin
            errors++; $display("FAIL good_pulse got=%0d want=1", done_count - dc);
        end
        checks++;
        if (cnt_evt !== 32'd1 || b_err !== 1'b0 || icrate_reg !== 5'd3 || islot_reg !== 5'd7 ||
            ievt_reg !== 16'h1234) begin
            errors++; $display("FAIL good_result got=%0d/%b/%0d/%0d/%h want=1/0/3/7/1234",
                               cnt_evt, b_err, icrate_reg, islot_reg, ievt_reg);
        end
    endtask

    task automatic test_pattern();
        do_reset();
        send_event(16'h1234, 5'd3, 5'd7, NDATA, 100, 5, 0, 1'b0, 5'b00010, 16'd2);
        wait_drain();
        checks++;
        if (cnt_bad !== 32'd1 || cnt_evt !== 32'd0 || err_cause !== 5'b00010) begin
            errors++; $display("FAIL pattern_counts got=%0d/%0d/%b want=1/0/00010", cnt_bad, cnt_evt, err_cause);
        end
    endtask

    task automatic test_length();
        do_reset();
        send_event(16'h0022, 5'd1, 5'd2, 1000, -1, 0, 0, 1'b0, 5'b00100, 16'd0);
        idle(3);
        send_event(16'h0023, 5'd1, 5'd2, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        wait_drain();
        checks++;
        if (cnt_bad !== 32'd1 || cnt_evt !== 32'd1) begin
            errors++; $display("FAIL length_counts got=%0d/%0d want=1/1", cnt_bad, cnt_evt);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_event(16'h1234, 5'd3, 5'd7, NDATA, -1, 0, 0, 1'b1, 5'b00000, 16'd0);
        wait_drain();
        checks++;
        if (cnt_evt !== 32'd1 || cnt_bad !== 32'd0 || ievt_reg !== 16'h1234 || cnt_header !== 32'd1) begin
            errors++; $display("FAIL gaps_result got=%0d/%0d/%h want=1/0/1234", cnt_evt, cnt_bad, ievt_reg);
        end
    endtask

    task automatic test_hdr_err();
        do_reset();
        push_exp(5'b00001, 16'd0, 1'b0, 16'h0, 5'd0, 5'd0);
        put(2'b11, 14'h0011, 1'b0);
        put(2'b11, 14'h0022, 1'b0);
        put(2'b11, 14'h0033, 1'b0);
        put(2'b10, 14'h0000, 1'b0);
        put(2'b10, 14'h0000, 1'b0);
        put(2'b01, 14'h0000, 1'b0);
        send_event(16'h0777, 5'd9, 5'd10, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        wait_drain();
        checks++;
        if (cnt_header !== 32'd1 || cnt_bad !== 32'd1 || cnt_evt !== 32'd1) begin
            errors++; $display("FAIL hdr_err_counts got=%0d/%0d/%0d want=1/1/1", cnt_header, cnt_bad, cnt_evt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_event(16'h0040, 5'd4, 5'd5, NDATA, -1, 0, 1, 1'b0, 5'b01000, 16'd0);
        send_event(16'h0041, 5'd6, 5'd8, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        wait_drain();
        checks++;
        if (cnt_bad !== 32'd1 || cnt_evt !== 32'd1 || ievt_reg !== 16'h0041 || icrate_reg !== 5'd6) begin
            errors++; $display("FAIL b2b_result got=%0d/%0d/%h/%0d want=1/1/0041/6", cnt_bad, cnt_evt, ievt_reg, icrate_reg);
        end
    endtask

    task automatic test_seq();
        logic [4:0] third;
`ifdef EVT_SEQ_CHECK_EN
        third = 5'b10000;
`else
        third = 5'b00000;
`endif
        do_reset();
        send_event(16'd5, 5'd1, 5'd1, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        send_event(16'd6, 5'd1, 5'd1, NDATA, -1, 0, 0, 1'b0, 5'b00000, 16'd0);
        send_event(16'd8, 5'd1, 5'd1, NDATA, -1, 0, 0, 1'b0, third, 16'd0);
        wait_drain();
        checks++;
        if (err_cause !== third) begin
            errors++; $display("FAIL seq_cause got=%b want=%b", err_cause, third);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        do_reset();
        dc = done_count;
        send_header(16'h0100, 5'd2, 5'd2, 1'b0);
        for (int k = 0; k < 500; k++) put(2'b10, 14'(k / STEP), 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; ivalid = 1'b0;
        #2;
        checks++;
        if (cnt_header !== '0 || cnt_evt !== '0 || cnt_bad !== '0 || evt_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_async got=%0d/%0d/%0d/%b want=0/0/0/0", cnt_header, cnt_evt, cnt_bad, evt_done);
        end
        idle(2);
        rst = 1'b0;
        put(2'b01, 14'h0, 1'b0);
        idle(20);
        checks++;
        if (cnt_header !== '0 || cnt_evt !== '0 || cnt_bad !== '0 || done_count != dc) begin
            errors++; $display("FAIL reset_mid_after got=%0d/%0d/%0d/%0d want=0/0/0/0",
                               cnt_header, cnt_evt, cnt_bad, done_count - dc);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_pattern();
        test_length();
        test_gaps();
        test_hdr_err();
        test_back_to_back();
        test_seq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
